// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline register bus: decode-side inputs, bypass inputs and ALU-side outputs.
interface id_ex_stage_if;
   logic        in_valid, in_ready;
   logic [4:0]  in_rs1, in_rs2, in_rd;
   logic [31:0] in_rs1_data, in_rs2_data, in_imm;
   logic [3:0]  in_operation;
   logic        in_alu_src, in_reg_write;
   logic        flush;
   logic        fwd_mem_we, fwd_wb_we;
   logic [4:0]  fwd_mem_rd, fwd_wb_rd;
   logic [31:0] fwd_mem_data, fwd_wb_data;
   logic        out_valid, out_ready;
   logic [31:0] ReadData1, ReadData2, out_store_data;
   logic [3:0]  Operation;
   logic [4:0]  out_rd;
   logic        out_reg_write;

   modport slave (
      input  in_valid, in_rs1, in_rs2, in_rd, in_rs1_data, in_rs2_data, in_imm,
             in_operation, in_alu_src, in_reg_write, flush,
             fwd_mem_we, fwd_mem_rd, fwd_mem_data, fwd_wb_we, fwd_wb_rd, fwd_wb_data,
             out_ready,
      output in_ready, out_valid, ReadData1, ReadData2, out_store_data,
             Operation, out_rd, out_reg_write
   );

   modport master (
      output in_valid, in_rs1, in_rs2, in_rd, in_rs1_data, in_rs2_data, in_imm,
             in_operation, in_alu_src, in_reg_write, flush,
             fwd_mem_we, fwd_mem_rd, fwd_mem_data, fwd_wb_we, fwd_wb_rd, fwd_wb_data,
             out_ready,
      input  in_ready, out_valid, ReadData1, ReadData2, out_store_data,
             Operation, out_rd, out_reg_write
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, flush, and MEM/WB operand bypass.
module id_ex_stage (
   input  logic          clock,
   input  logic          reset_n,
   id_ex_stage_if.slave  bus
);
   logic        valid_q, valid_d;
   logic [4:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic [31:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
   logic [3:0]  op_q, op_d;
   logic        alu_src_q, alu_src_d, reg_write_q, reg_write_d;

   logic        capture;
   logic        wb_hit_in1, wb_hit_in2, wb_hit_q1, wb_hit_q2;
   logic [31:0] fwd_rs1, fwd_rs2;

   assign bus.in_ready = (!valid_q || bus.out_ready) && !bus.flush;
   assign capture      = bus.in_valid && bus.in_ready;

   // WB matches on incoming indices (capture) and on held indices (stall refresh)
   assign wb_hit_in1 = bus.fwd_wb_we && (bus.fwd_wb_rd == bus.in_rs1) && (bus.in_rs1 != 5'd0);
   assign wb_hit_in2 = bus.fwd_wb_we && (bus.fwd_wb_rd == bus.in_rs2) && (bus.in_rs2 != 5'd0);
   assign wb_hit_q1  = bus.fwd_wb_we && (bus.fwd_wb_rd == rs1_q) && (rs1_q != 5'd0);
   assign wb_hit_q2  = bus.fwd_wb_we && (bus.fwd_wb_rd == rs2_q) && (rs2_q != 5'd0);

   always_comb begin
      valid_d     = valid_q;
      rs1_d       = rs1_q;
      rs2_d       = rs2_q;
      rd_d        = rd_q;
      rs1_data_d  = rs1_data_q;
      rs2_data_d  = rs2_data_q;
      imm_d       = imm_q;
      op_d        = op_q;
      alu_src_d   = alu_src_q;
      reg_write_d = reg_write_q;
      if (bus.flush) begin
         valid_d = 1'b0;
      end else if (capture) begin
         valid_d     = 1'b1;
         rs1_d       = bus.in_rs1;
         rs2_d       = bus.in_rs2;
         rd_d        = bus.in_rd;
         rs1_data_d  = wb_hit_in1 ? bus.fwd_wb_data : bus.in_rs1_data;
         rs2_data_d  = wb_hit_in2 ? bus.fwd_wb_data : bus.in_rs2_data;
         imm_d       = bus.in_imm;
         op_d        = bus.in_operation;
         alu_src_d   = bus.in_alu_src;
         reg_write_d = bus.in_reg_write;
      end else if (valid_q && bus.out_ready) begin
         valid_d = 1'b0;
      end else if (valid_q) begin
         // A stalled operand must not lose a value that retires from WB meanwhile
         if (wb_hit_q1) rs1_data_d = bus.fwd_wb_data;
         if (wb_hit_q2) rs2_data_d = bus.fwd_wb_data;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_q     <= 1'b0;
         rs1_q       <= 5'd0;
         rs2_q       <= 5'd0;
         rd_q        <= 5'd0;
         rs1_data_q  <= 32'd0;
         rs2_data_q  <= 32'd0;
         imm_q       <= 32'd0;
         op_q        <= 4'd0;
         alu_src_q   <= 1'b0;
         reg_write_q <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         rd_q        <= rd_d;
         rs1_data_q  <= rs1_data_d;
         rs2_data_q  <= rs2_data_d;
         imm_q       <= imm_d;
         op_q        <= op_d;
         alu_src_q   <= alu_src_d;
         reg_write_q <= reg_write_d;
      end
   end

   // MEM result is younger than WB, so it wins when both match
   always_comb begin
      fwd_rs1 = rs1_data_q;
      if (bus.fwd_mem_we && (bus.fwd_mem_rd == rs1_q) && (rs1_q != 5'd0))
         fwd_rs1 = bus.fwd_mem_data;
      else if (wb_hit_q1)
         fwd_rs1 = bus.fwd_wb_data;
   end

   always_comb begin
      fwd_rs2 = rs2_data_q;
      if (bus.fwd_mem_we && (bus.fwd_mem_rd == rs2_q) && (rs2_q != 5'd0))
         fwd_rs2 = bus.fwd_mem_data;
      else if (wb_hit_q2)
         fwd_rs2 = bus.fwd_wb_data;
   end

   assign bus.out_valid      = valid_q;
   assign bus.ReadData1      = fwd_rs1;
   assign bus.ReadData2      = alu_src_q ? imm_q : fwd_rs2;
   assign bus.out_store_data = fwd_rs2;
   assign bus.Operation      = op_q;
   assign bus.out_rd         = rd_q;
   assign bus.out_reg_write  = reg_write_q && valid_q;
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clock  in  1  sole clock; all state updates on rising edge.
REQ-002 reset_n  in  1  asynchronous, active-low reset; asserting clears all state immediately.
REQ-003 in_valid  in  1  decode stage presents an instruction.
REQ-004 in_ready  out  1  stage can accept this cycle.
REQ-005 in_rs1, in_rs2, in_rd  in  5 each  source/destination register indices.
REQ-006 in_rs1_data, in_rs2_data  in  32 each  register-file read values.
REQ-007 in_imm  in  32  sign-extended immediate.
REQ-008 in_operation  in  4  ALU operation code (0000 LD/SD ... 0111 ORI).
REQ-009 in_alu_src  in  1  1 = second ALU operand is immediate.
REQ-010 in_reg_write  in  1  instruction writes rd.
REQ-011 flush  in  1  discard held and incoming instruction.
REQ-012 fwd_mem_we, fwd_mem_rd[4:0], fwd_mem_data[31:0]  in  MEM-stage result bypass.
REQ-013 fwd_wb_we, fwd_wb_rd[4:0], fwd_wb_data[31:0]  in  WB-stage result bypass.
REQ-014 out_valid  out  1  ALU operands valid.
REQ-015 out_ready  in  1  execute stage consumes this cycle.
REQ-016 ReadData1, ReadData2  out  32 each  ALU operands.
REQ-017 Operation  out  4  ALU operation code.
REQ-018 out_store_data  out  32  forwarded rs2 value for SD.
REQ-019 out_rd  out  5; out_reg_write  out  1  destination and write enable.

Function
REQ-020 in_ready SHALL equal (!out_valid | out_ready) & !flush, combinational.
REQ-021 Capture (in_valid & in_ready) SHALL register all in_* fields and set out_valid next edge.
REQ-022 out_valid & out_ready without capture SHALL clear out_valid next edge.
REQ-023 out_valid & !out_ready SHALL hold all registered fields unchanged except per REQ-027.
REQ-024 flush SHALL clear out_valid next edge and block capture that cycle; flush has priority over all other updates.
REQ-025 Forwarded rsN value: fwd_mem_data if fwd_mem_we & fwd_mem_rd==rsN_q & rsN_q!=0; else fwd_wb_data if fwd_wb_we & fwd_wb_rd==rsN_q & rsN_q!=0; else registered rsN data; applied combinationally on registered indices.
REQ-026 ReadData1 SHALL be forwarded rs1; ReadData2 SHALL be imm_q if alu_src_q else forwarded rs2; out_store_data SHALL always be forwarded rs2.
REQ-027 While out_valid & !out_ready, a WB write (fwd_wb_we, rd!=0) matching rs1_q/rs2_q SHALL overwrite that held data register so the value survives WB retirement.
REQ-028 At capture, a same-cycle WB write matching in_rs1/in_rs2 (rd!=0) SHALL be captured in place of in_rsN_data.
REQ-029 Register x0 SHALL never be forwarded; rsN=0 yields the registered data (0 from regfile).
REQ-030 out_reg_write SHALL equal reg_write_q & out_valid; Operation, out_rd pass registered values.
REQ-031 Throughput SHALL be one instruction per cycle with out_ready held high; latency in->out one cycle.

Reset
REQ-032 reset_n low SHALL asynchronously force out_valid=0, Operation=0000, all data/index/control registers=0; ReadData1/2, out_store_data then 0 (no forwarding match on index 0).
REQ-033 Release SHALL be synchronous-safe; first capture possible on first edge with reset_n high; reset mid-stall discards the held instruction.

Verification
REQ-034 Streaming: 4 back-to-back ADDs, out_ready=1 -> out_valid each cycle from cycle 1, operands match inputs, Operation=0010.
REQ-035 MEM bypass priority: rs1=5, fwd_mem rd=5 data=0xAAAA0000, fwd_wb rd=5 data=0x1 -> ReadData1=0xAAAA0000.
REQ-036 Stall + WB update: hold out_ready=0, WB writes rd=7 data=0x1234 with rs2_q=7 for one cycle, then out_ready=1 -> ReadData2=0x1234 with alu_src=0.
REQ-037 Immediate/store: SD, alu_src=1, imm=0x10, rs2 data=0xDEAD -> ReadData2=0x10, out_store_data=0xDEAD, Operation=0000.
REQ-038 Flush with in_valid=1 and stalled output -> next cycle out_valid=0, out_reg_write=0, incoming instruction not captured.
REQ-039 x0 and reset: rs1=0 with fwd_mem rd=0 data=0xFFFF -> ReadData1=0; reset_n low mid-stall -> out_valid=0 immediately without clock edge.
